// File: rtl/wb_stage.sv
// Writeback stage: selects ALU / load / PC+4 result, waits for and extends load data, drives a one-cycle GPR write.
// Optional WB_BYPASS_EN builds registered fwd_* copies of the GPR write port; otherwise fwd_* are tied to 0.
module wb_stage #(
    parameter int DATA_W       = 32,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rd,
    input  logic [1:0]        in_wb_sel,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_pc4,
    input  logic [2:0]        in_funct3,
    input  logic [1:0]        in_addr_lo,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              gpr_we,
    output logic [4:0]        gpr_rd,
    output logic [DATA_W-1:0] gpr_di,
    output logic              busy,
    output logic [4:0]        busy_rd,
    output logic              load_err,
    output logic              fwd_valid,
    output logic [4:0]        fwd_rd,
    output logic [DATA_W-1:0] fwd_data
);
    localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD_WAIT = 2'd1, COMMIT = 2'd2} state_t;

    state_t            state, state_nx;
    logic [4:0]        rd_q, rd_nx;
    logic [DATA_W-1:0] data_q, data_nx;
    logic [2:0]        f3_q, f3_nx;
    logic [1:0]        lo_q, lo_nx;
    logic [CNT_W-1:0]  cnt_q, cnt_nx;
    logic              err_q, err_nx;
    logic              accept;
    logic              misaligned;

    // funct3[1] set means word (covers 010, 011, 11x); funct3[1:0]=01 is a halfword.
    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] f3,
                                                input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        if (f3[1])      return w;
        else if (f3[0]) return f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
        else            return f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rd_q   <= '0;
            data_q <= '0;
            f3_q   <= '0;
            lo_q   <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            rd_q   <= rd_nx;
            data_q <= data_nx;
            f3_q   <= f3_nx;
            lo_q   <= lo_nx;
            cnt_q  <= cnt_nx;
            err_q  <= err_nx;
        end
    end

    assign accept     = in_valid && in_ready;
    assign misaligned = in_funct3[1] ? (in_addr_lo != 2'd0) : (in_funct3[0] && in_addr_lo[0]);

    always_comb begin
        state_nx = state;
        rd_nx    = rd_q;
        data_nx  = data_q;
        f3_nx    = f3_q;
        lo_nx    = lo_q;
        cnt_nx   = cnt_q;
        err_nx   = 1'b0;
        case (state)
            LOAD_WAIT: begin
                // Data arriving on the timeout cycle still wins.
                if (mem_rvalid) begin
                    state_nx = COMMIT;
                    data_nx  = load_extend(mem_rdata, f3_q, lo_q);
                end else if (cnt_q == CNT_LAST) begin
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt_q + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                if (accept) begin
                    case (in_wb_sel)
                        2'b01: begin
                            state_nx = COMMIT;
                            rd_nx    = in_rd;
                            data_nx  = in_alu_res;
                        end
                        2'b11: begin
                            state_nx = COMMIT;
                            rd_nx    = in_rd;
                            data_nx  = in_pc4;
                        end
                        2'b10: begin
                            rd_nx = in_rd;
                            f3_nx = in_funct3;
                            lo_nx = in_addr_lo;
                            if (misaligned) begin
                                err_nx = 1'b1;
                            end else begin
                                state_nx = LOAD_WAIT;
                                cnt_nx   = '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        in_ready = (state != LOAD_WAIT);
        gpr_we   = (state == COMMIT) && (rd_q != 5'd0);
        gpr_rd   = gpr_we ? rd_q : 5'd0;
        gpr_di   = gpr_we ? data_q : '0;
        busy     = (state != IDLE) && (rd_q != 5'd0);
        busy_rd  = busy ? rd_q : 5'd0;
        load_err = err_q;
    end

`ifdef WB_BYPASS_EN
    logic fwd_we_nx;
    assign fwd_we_nx = (state_nx == COMMIT) && (rd_nx != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_valid <= 1'b0;
            fwd_rd    <= '0;
            fwd_data  <= '0;
        end else begin
            fwd_valid <= fwd_we_nx;
            fwd_rd    <= fwd_we_nx ? rd_nx : 5'd0;
            fwd_data  <= fwd_we_nx ? data_nx : '0;
        end
    end
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = 5'd0;
    assign fwd_data  = '0;
`endif
endmodule
